// File: rtl/spectral_power_accumulator_pkg.sv
// Shared defaults and pipeline control types for the spectral power accumulator.
package spectral_power_accumulator_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 16;
    localparam int DEFAULT_FFT_POINTS_LOG2 = 8;
    localparam int DEFAULT_NUM_AVG         = 16;
    localparam int DEFAULT_ACC_WIDTH       = 40;

    // Input sample to output register, in clock edges (S0..S3).
    localparam int PIPE_DEPTH = 4;

    // Control bits that travel alongside each bin through the pipeline.
    typedef struct packed {
        logic valid;     // slot carries a real bin
        logic first;     // bin belongs to frame 0 of the integration (overwrite)
        logic is_final;  // bin belongs to the last frame (emit result)
        logic sync_err;  // i_last disagreed with the bin counter for this bin
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_IDLE = '0;

endpackage

// File: rtl/spectral_power_accumulator_accum_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with a
// registered (1-cycle) read. No reset; contents are overwritten by frame 0.
module spectral_power_accumulator_accum_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port and synchronous read port; same-address collisions never occur in use.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spectral_power_accumulator.sv
// Spectral power accumulator: |X|^2 per FFT bin, integrated over NUM_AVG
// frames in on-chip RAM, one averaged spectrum emitted per integration.
// Four-stage stall-free pipeline:
//   S0 register inputs/bin/flags, issue RAM read
//   S1 squares + RAM read data
//   S2 power sum, RAM data held alongside
//   S3 overwrite or saturating add, RAM write-back, output registers
// There is no backpressure: every input slot advances one stage per cycle.
module spectral_power_accumulator
    import spectral_power_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int FFT_POINTS_LOG2 = DEFAULT_FFT_POINTS_LOG2,
    parameter int NUM_AVG         = DEFAULT_NUM_AVG,
    parameter int ACC_WIDTH       = DEFAULT_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_WIDTH-1:0] i_re,
    input  logic signed [DATA_WIDTH-1:0] i_im,
    input  logic                        i_valid,
    input  logic                        i_last,
    output logic [FFT_POINTS_LOG2-1:0]  o_bin,
    output logic [ACC_WIDTH-1:0]        o_power,
    output logic                        o_valid,
    output logic                        o_last,
    output logic                        o_sat,
    output logic                        o_sync_err
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int PWR_W  = 2 * DATA_WIDTH + 1;
    localparam int FW     = $clog2(NUM_AVG);
    localparam int NSTG   = PIPE_DEPTH - 1;  // S0..S2 registers ahead of S3

    localparam logic [FFT_POINTS_LOG2-1:0] LAST_BIN   = '1;
    localparam logic [FW-1:0]              LAST_FRAME = FW'(NUM_AVG - 1);

    // ---------------- counters ----------------
    logic [FFT_POINTS_LOG2-1:0] bin_q, bin_d;
    logic [FW-1:0]              frame_q, frame_d;
    logic                       frame_end;
    stage_ctrl_t                s0_ctrl_d;

    // Next bin/frame counters and the control word for the incoming bin.
    always_comb begin
        bin_d     = bin_q;
        frame_d   = frame_q;
        frame_end = i_valid && ((bin_q == LAST_BIN) || i_last);
        if (i_valid) begin
            if (frame_end) begin
                bin_d   = '0;
                frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
            end else begin
                bin_d = bin_q + 1'b1;
            end
        end
        s0_ctrl_d.valid    = i_valid;
        s0_ctrl_d.first    = (frame_q == '0);
        s0_ctrl_d.is_final = (frame_q == LAST_FRAME);
        s0_ctrl_d.sync_err = i_valid && ((bin_q == LAST_BIN) != i_last);
    end

    // Bin and frame counter registers; reset discards any partial integration.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            frame_q <= '0;
        end else begin
            bin_q   <= bin_d;
            frame_q <= frame_d;
        end
    end

    // ---------------- pipeline ----------------
    stage_ctrl_t                ctrl_q    [0:NSTG-1];
    logic [FFT_POINTS_LOG2-1:0] bin_pipe_q[0:NSTG-1];

    logic signed [DATA_WIDTH-1:0] s0_re_q, s0_im_q;
    logic signed [PROD_W-1:0]     re_ext, im_ext;
    logic signed [PROD_W-1:0]     s1_sq_re_q, s1_sq_im_q;
    logic [PWR_W-1:0]             s2_p_q;
    logic [ACC_WIDTH-1:0]         s2_rd_q;
    logic [ACC_WIDTH-1:0]         ram_rdata;

    assign re_ext = PROD_W'(s0_re_q);
    assign im_ext = PROD_W'(s0_im_q);

    // Control shift register: only the valid bits need a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                ctrl_q[i] <= STAGE_IDLE;
            end
        end else begin
            ctrl_q[0] <= s0_ctrl_d;
            for (int i = 1; i < NSTG; i++) begin
                ctrl_q[i] <= ctrl_q[i-1];
            end
        end
    end

    // Datapath registers S0..S2; bubbles carry don't-care data.
    always_ff @(posedge clk) begin
        s0_re_q       <= i_re;
        s0_im_q       <= i_im;
        bin_pipe_q[0] <= bin_q;
        for (int i = 1; i < NSTG; i++) begin
            bin_pipe_q[i] <= bin_pipe_q[i-1];
        end
        s1_sq_re_q <= re_ext * re_ext;
        s1_sq_im_q <= im_ext * im_ext;
        // Squares are never negative, so their bit patterns add as unsigned.
        s2_p_q     <= {1'b0, s1_sq_re_q} + {1'b0, s1_sq_im_q};
        s2_rd_q    <= ram_rdata;
    end

    // ---------------- S3: accumulate ----------------
    stage_ctrl_t          s2_ctrl;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] acc_d;

    assign s2_ctrl = ctrl_q[NSTG-1];

    // Frame 0 overwrites stale RAM; later frames add with clamp to all-ones.
    always_comb begin
        p_ext = ACC_WIDTH'(s2_p_q);
        sum   = {1'b0, s2_rd_q} + {1'b0, p_ext};
        ovf   = sum[ACC_WIDTH];
        if (s2_ctrl.first) begin
            acc_d = p_ext;
        end else if (ovf) begin
            acc_d = '1;
        end else begin
            acc_d = sum[ACC_WIDTH-1:0];
        end
    end

    // A bin's next read happens at least N>=4 slots later, after this write lands.
    spectral_power_accumulator_accum_ram #(
        .ADDR_WIDTH (FFT_POINTS_LOG2),
        .DATA_WIDTH (ACC_WIDTH)
    ) u_accum_ram (
        .clk     (clk),
        .we_i    (s2_ctrl.valid),
        .waddr_i (bin_pipe_q[NSTG-1]),
        .wdata_i (acc_d),
        .raddr_i (bin_pipe_q[0]),
        .rdata_o (ram_rdata)
    );

    // ---------------- outputs ----------------
    logic [FFT_POINTS_LOG2-1:0] o_bin_q;
    logic [ACC_WIDTH-1:0]       o_power_q;
    logic                       o_valid_q, o_last_q, o_sat_q, o_sync_err_q;

    // Output registers: bin/power hold between results; sat is sticky per integration.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_bin_q      <= '0;
            o_power_q    <= '0;
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            o_sat_q      <= 1'b0;
            o_sync_err_q <= 1'b0;
        end else begin
            o_valid_q    <= s2_ctrl.valid && s2_ctrl.is_final;
            o_last_q     <= s2_ctrl.valid && s2_ctrl.is_final && (bin_pipe_q[NSTG-1] == LAST_BIN);
            o_sync_err_q <= s2_ctrl.valid && s2_ctrl.sync_err;
            if (s2_ctrl.valid && s2_ctrl.is_final) begin
                o_bin_q   <= bin_pipe_q[NSTG-1];
                o_power_q <= acc_d;
            end
            if (s2_ctrl.valid) begin
                if (s2_ctrl.first) begin
                    o_sat_q <= 1'b0;
                end else if (ovf) begin
                    o_sat_q <= 1'b1;
                end
            end
        end
    end

    assign o_bin      = o_bin_q;
    assign o_power    = o_power_q;
    assign o_valid    = o_valid_q;
    assign o_last     = o_last_q;
    assign o_sat      = o_sat_q;
    assign o_sync_err = o_sync_err_q;

endmodule

// File: tb/tb_spectral_power_accumulator.sv
// Bench for spectral_power_accumulator with N=8, NUM_AVG=4, ACC_WIDTH=33.
// A per-bin integration model schedules each input's expected output slot
// PIPE_DEPTH cycles later; a compare process checks every output every cycle.
module tb_spectral_power_accumulator;
    import spectral_power_accumulator_pkg::*;

    localparam int DW   = 16;
    localparam int L2   = 3;
    localparam int N    = 1 << L2;
    localparam int NA   = 4;
    localparam int AW   = 33;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] i_re = '0;
    logic signed [DW-1:0] i_im = '0;
    logic                 i_valid = 1'b0;
    logic                 i_last = 1'b0;
    logic [L2-1:0]        o_bin;
    logic [AW-1:0]        o_power;
    logic                 o_valid, o_last, o_sat, o_sync_err;

    always #5 clk = ~clk;

    spectral_power_accumulator #(
        .DATA_WIDTH      (DW),
        .FFT_POINTS_LOG2 (L2),
        .NUM_AVG         (NA),
        .ACC_WIDTH       (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_re       (i_re),
        .i_im       (i_im),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .o_bin      (o_bin),
        .o_power    (o_power),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .o_sat      (o_sat),
        .o_sync_err (o_sync_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    typedef struct {
        int     due;
        bit     vld;
        int     bin;
        longint pwr;
        bit     last;
        bit     sat;
        bit     err;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc[N];
    int     m_bin = 0;
    int     m_frame = 0;
    bit     m_sat = 1'b0;
    longint h_pwr = 0;
    int     h_bin = 0;
    bit     h_sat = 1'b0;
    int     out_cnt = 0;
    int     err_cnt = 0;
    bit     chk_en = 1'b0;

    // Integration rules applied to one accepted bin, result due PIPE_DEPTH cycles later.
    task automatic model_send(input int re, input int im, input bit last);
        longint p, s;
        int     b;
        bit     first, fin;
        exp_t   e;
        p     = longint'(re) * re + longint'(im) * im;
        b     = m_bin;
        first = (m_frame == 0);
        fin   = (m_frame == NA - 1);
        s     = m_acc[b] + p;
        if (first) begin
            m_acc[b] = p;
            if (b == 0) m_sat = 1'b0;
        end else if (s > MAXV) begin
            m_acc[b] = MAXV;
            m_sat    = 1'b1;
        end else begin
            m_acc[b] = s;
        end
        e.due  = cyc + PIPE_DEPTH;
        e.vld  = fin;
        e.bin  = b;
        e.pwr  = m_acc[b];
        e.last = fin && (b == N - 1);
        e.sat  = m_sat;
        e.err  = (last != (b == N - 1));
        exp_q.push_back(e);
        if (last || b == N - 1) begin
            m_bin   = 0;
            m_frame = (m_frame + 1) % NA;
        end else begin
            m_bin++;
        end
    endtask

    // Compare every output against the model on every cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   vld, lst, err;
        if (chk_en) begin
            vld = 1'b0;
            lst = 1'b0;
            err = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e     = exp_q.pop_front();
                vld   = e.vld;
                lst   = e.last;
                err   = e.err;
                h_sat = e.sat;
                if (e.vld) begin
                    h_bin = e.bin;
                    h_pwr = e.pwr;
                end
            end
            check("o_valid", o_valid, vld);
            check("o_last", o_last, lst);
            check("o_sync_err", o_sync_err, err);
            check("o_sat", o_sat, h_sat);
            check("o_bin", o_bin, h_bin);
            check("o_power", o_power, h_pwr);
            if (o_valid === 1'b1) out_cnt++;
            if (o_sync_err === 1'b1) err_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int re, input int im, input bit last);
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_re    = DW'(re);
        i_im    = DW'(im);
        i_last  = last;
        model_send(re, im, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
    endtask

    // last_at = bin carrying i_last (N-1 normal, <N-1 early, -1 never).
    task automatic run_frame(input int re, input int im, input int last_at, input bit gap);
        int len;
        len = (last_at >= 0 && last_at < N - 1) ? last_at + 1 : N;
        for (int b = 0; b < len; b++) begin
            send(re, im, b == last_at);
            if (gap) idle(1);
        end
    endtask

    task automatic run_integ(input int re, input int im, input bit gap);
        for (int f = 0; f < NA; f++) run_frame(re, im, N - 1, gap);
        idle(PIPE_DEPTH + 2);
    endtask

    task automatic do_reset();
        idle(PIPE_DEPTH + 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_bin   = 0;
        m_frame = 0;
        m_sat   = 1'b0;
        h_pwr   = 0;
        h_bin   = 0;
        h_sat   = 1'b0;
        rst     = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c0, e0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_last", o_last, 0);
        check("rst_o_sat", o_sat, 0);
        check("rst_o_sync_err", o_sync_err, 0);
        check("rst_o_bin", o_bin, 0);
        check("rst_o_power", o_power, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: 3+4j everywhere, back-to-back frames
        c0 = out_cnt;
        run_integ(3, 4, 1'b0);
        check("t1_count", out_cnt - c0, 8);
        check("t1_power", o_power, 100);
        check("t1_bin", o_bin, 7);
        check("t1_model", m_acc[3], 100);

        // 2: same values, one idle cycle between bins
        c0 = out_cnt;
        run_integ(3, 4, 1'b1);
        check("t2_count", out_cnt - c0, 8);
        check("t2_power", o_power, 100);

        // 3: full-scale negative inputs, 4 * 2^31 = 2^33 saturates
        c0 = out_cnt;
        run_integ(-32768, -32768, 1'b0);
        check("t3_count", out_cnt - c0, 8);
        check("t3_power", o_power, 64'd8589934591);
        check("t3_sat", o_sat, 1);

        // 4: frame 0 lacks i_last, frame 3 ends early at bin 5
        c0 = out_cnt;
        e0 = err_cnt;
        run_frame(1, 2, -1, 1'b0);
        run_frame(1, 2, N - 1, 1'b0);
        run_frame(1, 2, N - 1, 1'b0);
        run_frame(1, 2, 5, 1'b0);
        idle(PIPE_DEPTH + 2);
        check("t4_count", out_cnt - c0, 6);
        check("t4_err_pulses", err_cnt - e0, 2);
        check("t4_bin", o_bin, 5);
        check("t4_power", o_power, 20);
        check("t4_sat_cleared", o_sat, 0);
        c0 = out_cnt;
        run_integ(2, 0, 1'b0);
        check("t4_next_count", out_cnt - c0, 8);
        check("t4_next_power", o_power, 16);

        // 5: partial integration discarded by reset
        c0 = out_cnt;
        run_frame(3, 0, N - 1, 1'b0);
        run_frame(3, 0, N - 1, 1'b0);
        do_reset();
        check("t5_pre_rst_count", out_cnt - c0, 0);
        check("t5_rst_power", o_power, 0);
        run_integ(1, 0, 1'b0);
        check("t5_count", out_cnt - c0, 8);
        check("t5_power", o_power, 4);

        // 6: p=25 integration followed by p=4 integration
        run_integ(0, 5, 1'b0);
        check("t6a_power", o_power, 100);
        c0 = out_cnt;
        run_integ(2, 0, 1'b0);
        check("t6_count", out_cnt - c0, 8);
        check("t6_power", o_power, 16);
        check("t6_sat", o_sat, 0);

        idle(PIPE_DEPTH + 2);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
